// File: rtl/scripted_player.sv
// scripted_player
// Replays a programmable script of cell indices onto the shared board bus
// (update_loc/submit/reset) whenever turn selects the player. It supports an
// accept/reject handshake, an acknowledge timeout, restart on new_game and a
// sticky error flag.
// Optional feature: define PLAYER_RETRY_SCAN_EN to make a rejected move scan
// forward cell by cell from the last submitted location instead of skipping
// to the next script entry.
module scripted_player #(
  parameter int BOARD_N      = 3,
  parameter int IDX_W        = 4,
  parameter int SCRIPT_DEPTH = 8,
  parameter int PTR_W        = 3,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             turn,
  input  logic             game_over,
  input  logic             accept,
  input  logic             reject,
  input  logic             new_game,
  input  logic             prog_we,
  input  logic [PTR_W-1:0] prog_addr,
  input  logic [IDX_W-1:0] prog_loc,
  output logic [IDX_W-1:0] update_loc,
  output logic             submit,
  output logic             reset,
  output logic [PTR_W:0]   move_count,
  output logic             done,
  output logic             error
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [PTR_W:0]   DEPTH_V = (PTR_W+1)'(SCRIPT_DEPTH);
  localparam logic [IDX_W:0]   CELLS_V = (IDX_W+1)'(CELLS);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_RETRY,
    S_RELEASE,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  // The pointer is one bit wider than an address so it can reach SCRIPT_DEPTH.
  logic [PTR_W:0]   ptr_q, ptr_d, ptr_inc;
  logic [PTR_W:0]   mc_q, mc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] loc_q, loc_d;
  logic             sub_q, sub_d;
  logic             brst_q, brst_d;
  logic [TO_W-1:0]  tmr_q, tmr_d;

  logic [IDX_W-1:0] mem [SCRIPT_DEPTH];
  logic [IDX_W-1:0] entry_loc;
  logic [IDX_W-1:0] issue_loc;
  logic             retry_end;

  assign entry_loc = mem[ptr_q[PTR_W-1:0]];
  assign ptr_inc   = ptr_q + (PTR_W+1)'(1);

`ifdef PLAYER_RETRY_SCAN_EN
  localparam int               SC_W      = $clog2(CELLS + 1);
  localparam logic [SC_W-1:0]  SCAN_MAX  = SC_W'(CELLS);
  localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(CELLS - 1);

  logic             scan_q, scan_d;
  logic [SC_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0] scan_loc;

  // While scanning, the next candidate is the cell after the last one submitted.
  assign scan_loc  = (loc_q >= LAST_CELL) ? '0 : loc_q + IDX_W'(1);
  assign issue_loc = scan_q ? scan_loc : entry_loc;
  assign retry_end = (scan_cnt_q == SCAN_MAX);
`else
  assign issue_loc = entry_loc;
  assign retry_end = (ptr_q == DEPTH_V);
`endif

  // Script memory: programmable at any time, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (prog_we && ({1'b0, prog_addr} < DEPTH_V)) begin
      mem[prog_addr] <= prog_loc;
    end
  end

  // Next-state and next-register logic; new_game outranks everything, then game_over
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mc_d    = mc_q;
    done_d  = done_q;
    err_d   = err_q;
    loc_d   = loc_q;
    sub_d   = 1'b0;
    brst_d  = 1'b0;
    tmr_d   = tmr_q;
`ifdef PLAYER_RETRY_SCAN_EN
    scan_d     = scan_q;
    scan_cnt_d = scan_cnt_q;
`endif
    if (new_game) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      mc_d    = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      brst_d  = 1'b1;
      tmr_d   = '0;
`ifdef PLAYER_RETRY_SCAN_EN
      scan_d     = 1'b0;
      scan_cnt_d = '0;
`endif
    end else if (game_over && (state_q != S_HALT)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!turn && !done_q && !err_q) state_d = S_ISSUE;
        end
        S_ISSUE: begin
          if ({1'b0, issue_loc} >= CELLS_V) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            loc_d   = issue_loc;
            sub_d   = 1'b1;
            tmr_d   = '0;
            state_d = S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          // A simultaneous accept and reject is treated as a reject.
          if (reject) begin
`ifdef PLAYER_RETRY_SCAN_EN
            scan_d     = 1'b1;
            scan_cnt_d = scan_cnt_q + SC_W'(1);
`else
            ptr_d      = ptr_inc;
`endif
            state_d = S_RETRY;
          end else if (accept) begin
            ptr_d   = ptr_inc;
            mc_d    = (mc_q >= DEPTH_V) ? mc_q : mc_q + (PTR_W+1)'(1);
            if (ptr_inc == DEPTH_V) done_d = 1'b1;
`ifdef PLAYER_RETRY_SCAN_EN
            scan_d     = 1'b0;
            scan_cnt_d = '0;
`endif
            state_d = S_RELEASE;
          end else if (tmr_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            tmr_d = tmr_q + TO_W'(1);
          end
        end
        S_RETRY: begin
          if (retry_end) begin
            done_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_RELEASE: begin
          if (turn) state_d = S_IDLE;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and control/bus registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      mc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      loc_q   <= '0;
      sub_q   <= 1'b0;
      brst_q  <= 1'b0;
      tmr_q   <= '0;
`ifdef PLAYER_RETRY_SCAN_EN
      scan_q     <= 1'b0;
      scan_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mc_q    <= mc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      loc_q   <= loc_d;
      sub_q   <= sub_d;
      brst_q  <= brst_d;
      tmr_q   <= tmr_d;
`ifdef PLAYER_RETRY_SCAN_EN
      scan_q     <= scan_d;
      scan_cnt_q <= scan_cnt_d;
`endif
    end
  end

  // The bus is released combinationally whenever it is the AI's turn.
  assign update_loc = turn ? {IDX_W{1'bz}} : loc_q;
  assign submit     = turn ? 1'bz : sub_q;
  assign reset      = turn ? 1'bz : brst_q;

  assign move_count = mc_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_scripted_player.sv
// Testbench for scripted_player: directed scenarios plus randomized games
// checked against a move-level model of the player.
module tb_scripted_player;

  localparam int BOARD_N      = 3;
  localparam int IDX_W        = 4;
  localparam int SCRIPT_DEPTH = 5;
  localparam int PTR_W        = 3;
  localparam int ACK_TIMEOUT  = 15;
  localparam int CELLS        = BOARD_N * BOARD_N;
  localparam int FLOAT_LOC    = (1 << IDX_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             turn;
  logic             game_over;
  logic             accept;
  logic             reject;
  logic             new_game;
  logic             prog_we;
  logic [PTR_W-1:0] prog_addr;
  logic [IDX_W-1:0] prog_loc;
  // Pulled-up bus: a released line reads as all ones.
  tri1  [IDX_W-1:0] update_loc;
  tri1              submit;
  tri1              reset;
  logic [PTR_W:0]   move_count;
  logic             done;
  logic             error;

  int checks = 0;
  int errors = 0;

  int scr   [SCRIPT_DEPTH];
  int react [16];   // 0 = accept, 1 = reject, 2 = accept and reject together

  // Move-level reference model state
  int m_idx, m_mc, m_last, m_scan;
  bit m_done, m_err;

  scripted_player #(
    .BOARD_N(BOARD_N), .IDX_W(IDX_W), .SCRIPT_DEPTH(SCRIPT_DEPTH),
    .PTR_W(PTR_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .turn(turn), .game_over(game_over),
    .accept(accept), .reject(reject), .new_game(new_game),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_loc(prog_loc),
    .update_loc(update_loc), .submit(submit), .reset(reset),
    .move_count(move_count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic restart();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  task automatic load_script();
    for (int i = 0; i < SCRIPT_DEPTH; i++) begin
      prog_we   = 1'b1;
      prog_addr = PTR_W'(i);
      prog_loc  = IDX_W'(scr[i]);
      tick();
    end
    prog_we = 1'b0;
  endtask

  // Wait (bounded) for a submit strobe; lat counts falling edges waited.
  task automatic wait_submit(output int lat, output int loc, output bit seen);
    seen = 1'b0;
    lat  = 0;
    loc  = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (submit === 1'b1) begin
        seen = 1'b1;
        lat  = i;
        loc  = int'(update_loc);
      end
    end
  endtask

  task automatic quiet_window(input int n, output bit saw);
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (submit === 1'b1) saw = 1'b1;
    end
  endtask

  function automatic void m_start();
    m_idx = 0; m_mc = 0; m_last = 0; m_scan = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic int m_next();
    if (m_scan > 0) return (m_last + 1) % CELLS;
    return scr[m_idx];
  endfunction

  function automatic void m_result(input int loc, input bit acc);
    if (acc) begin
      m_idx++;
      m_mc++;
      m_scan = 0;
      if (m_idx == SCRIPT_DEPTH) m_done = 1;
    end else begin
`ifdef PLAYER_RETRY_SCAN_EN
      m_scan++;
      m_last = loc;
      if (m_scan == CELLS) m_done = 1;
`else
      m_idx++;
      if (m_idx == SCRIPT_DEPTH) m_done = 1;
`endif
    end
  endfunction

  // Play one game from IDLE (turn=1 on entry) using the react[] table.
  task automatic run_game();
    int lat, loc, k, r;
    bit seen, acc, fresh, saw;
    m_start();
    k = 0;
    fresh = 1'b1;
    turn = 1'b0;
    while (!m_done && !m_err) begin
      if (m_next() >= CELLS) begin
        quiet_window(4, saw);
        chk("bad_entry_no_submit", int'(saw), 0);
        m_err = 1;
      end else begin
        wait_submit(lat, loc, seen);
        chk("submit_seen", int'(seen), 1);
        if (!seen) break;
        chk("submit_loc", loc, m_next());
        if (fresh) chk("turn_latency", lat, 2);
        r = react[k % 16];
        k++;
        acc    = (r == 0);
        accept = (r != 1);
        reject = (r != 0);
        tick();
        accept = 1'b0;
        reject = 1'b0;
        m_result(loc, acc);
        fresh = acc;
        if (acc) begin
          turn = 1'b1;
          tick();
          tick();
          if (!m_done) turn = 1'b0;
        end
      end
    end
    turn = 1'b0;
    quiet_window(6, saw);
    chk("no_extra_submit", int'(saw), 0);
    chk("move_count", int'(move_count), (m_mc > SCRIPT_DEPTH) ? SCRIPT_DEPTH : m_mc);
    chk("done", int'(done), int'(m_done));
    chk("error", int'(error), int'(m_err));
    turn = 1'b1;
    tick();
  endtask

  initial begin
    int lat, loc, n;
    bit seen, saw;
    rst_n = 1'b0; turn = 1'b0; game_over = 1'b0; accept = 1'b0; reject = 1'b0;
    new_game = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_loc = '0;

    // Reset state with the bus owned by the player
    tick(); tick();
    chk("rst_loc", int'(update_loc), 0);
    chk("rst_submit", int'(submit), 0);
    chk("rst_reset", int'(reset), 0);
    chk("rst_move_count", int'(move_count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    turn = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // AI owns the bus: everything floats, even across a restart
    restart();
    for (int i = 0; i < 4; i++) begin
      chk("z_loc", int'(update_loc), FLOAT_LOC);
      chk("z_submit", int'(submit), 1);
      chk("z_reset", int'(reset), 1);
      tick();
    end
    chk("z_move_count", int'(move_count), 0);

    // Full script, every move accepted
    scr = '{4, 3, 6, 8, 1};
    react = '{default: 0};
    load_script();
    restart();
    run_game();

    // Second move rejected
    scr = '{4, 4, 0, 2, 7};
    react = '{default: 0};
    react[1] = 1;
    load_script();
    restart();
    run_game();

    // Out-of-range first entry
    scr = '{9, 1, 2, 3, 4};
    react = '{default: 0};
    load_script();
    restart();
    run_game();
    restart();
    chk("restart_clears_error", int'(error), 0);

    // Board never acknowledges
    scr = '{7, 2, 3, 4, 5};
    load_script();
    restart();
    turn = 1'b0;
    wait_submit(lat, loc, seen);
    chk("to_submit_loc", loc, 7);
    n = 0;
    saw = 1'b0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick();
      if (submit === 1'b1) saw = 1'b1;
      if (error === 1'b1) n = i;
    end
    chk("timeout_cycles", n, ACK_TIMEOUT);
    quiet_window(5, seen);
    chk("timeout_no_resubmit", int'(saw | seen), 0);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("new_game_reset_pulse", int'(reset), 1);
    chk("new_game_error_clear", int'(error), 0);
    tick();
    chk("new_game_reset_end", int'(reset), 0);
    wait_submit(lat, loc, seen);
    chk("restart_loc", loc, 7);
    // Turn passes to the AI mid-handshake; the accept still counts
    turn = 1'b1;
    tick();
    accept = 1'b1;
    tick();
    accept = 1'b0;
    tick();
    chk("late_accept_count", int'(move_count), 1);

    // game_over holds the player in IDLE and freezes its progress
    scr = '{5, 6, 7, 8, 0};
    load_script();
    restart();
    game_over = 1'b1;
    turn = 1'b0;
    quiet_window(6, saw);
    chk("game_over_no_submit", int'(saw), 0);
    game_over = 1'b0;
    wait_submit(lat, loc, seen);
    chk("after_game_over_lat", lat, 2);
    chk("after_game_over_loc", loc, 5);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    wait_submit(lat, loc, seen);
    chk("held_ptr_loc", loc, 5);
    chk("held_move_count", int'(move_count), 0);
    turn = 1'b1;

    // Asynchronous reset in the middle of a handshake
    scr = '{4, 3, 6, 8, 1};
    load_script();
    restart();
    turn = 1'b0;
    wait_submit(lat, loc, seen);
    accept = 1'b1;
    tick();
    accept = 1'b0;
    turn = 1'b1;
    tick(); tick();
    turn = 1'b0;
    wait_submit(lat, loc, seen);
    chk("pre_reset_loc", loc, 3);
    chk("pre_reset_count", int'(move_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_loc", int'(update_loc), 0);
    chk("async_count", int'(move_count), 0);
    chk("async_submit", int'(submit), 0);
    turn = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    turn = 1'b0;
    wait_submit(lat, loc, seen);
    chk("replay_lat", lat, 2);
    chk("replay_loc", loc, 4);
    turn = 1'b1;
    tick();

    // Randomized games
    for (int g = 0; g < 20; g++) begin
      for (int i = 0; i < SCRIPT_DEPTH; i++) begin
        if ($urandom_range(0, 9) == 0) scr[i] = int'($urandom_range(CELLS, FLOAT_LOC));
        else scr[i] = int'($urandom_range(0, CELLS - 1));
      end
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 9) < 6) react[i] = 0;
        else react[i] = int'($urandom_range(1, 2));
      end
      load_script();
      restart();
      run_game();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
